// File: rtl/input_conditioner.sv
// input_conditioner: 2-FF sync, per-channel debounce, press/release pulses, press counters, optional long-press
//   Ports: clk27 (27 MHz clock), reset_n (async active-low reset), in_raw[CHANNELS] (async pins),
//   clear_cnt (sync clear of press counters), in_stable[CHANNELS] (debounced level, IDLE_LEVEL polarity),
//   press_pulse/release_pulse[CHANNELS] (1-cycle accepted-edge pulses), press_cnt[CHANNELS*CNT_W]
//   (channel i at [i*CNT_W +: CNT_W]), long_press[CHANNELS] (1-cycle pulse per long hold), any_pressed.
//   Macro INPUT_COND_LONGPRESS_EN enables the long-press hold counters; without it long_press is tied 0.
module input_conditioner #(
  parameter int                  CHANNELS         = 2,
  parameter logic [CHANNELS-1:0] IDLE_LEVEL       = {CHANNELS{1'b1}},
  parameter int                  DEBOUNCE_CYCLES  = 270000,
  parameter int                  LONGPRESS_CYCLES = 27000000,
  parameter int                  CNT_W            = 8
) (
  input  logic                      clk27,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       in_raw,
  input  logic                      clear_cnt,
  output logic [CHANNELS-1:0]       in_stable,
  output logic [CHANNELS-1:0]       press_pulse,
  output logic [CHANNELS-1:0]       release_pulse,
  output logic [CHANNELS*CNT_W-1:0] press_cnt,
  output logic [CHANNELS-1:0]       long_press,
  output logic                      any_pressed
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
`ifdef INPUT_COND_LONGPRESS_EN
  localparam int HW = $clog2(LONGPRESS_CYCLES + 1);
  localparam logic [HW-1:0] LP_LAST = HW'(LONGPRESS_CYCLES - 1);
  localparam logic [HW-1:0] LP_FULL = HW'(LONGPRESS_CYCLES);
`endif
  if (DEBOUNCE_CYCLES < 1 || LONGPRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("input_conditioner: need DEBOUNCE_CYCLES >= 1 and LONGPRESS_CYCLES > DEBOUNCE_CYCLES");
  end
  logic [CHANNELS-1:0] r_s1, r_s2, w_stable;
  logic                r_any;
  always_ff @(posedge clk27 or negedge reset_n)
    if (!reset_n) begin
      r_s1  <= IDLE_LEVEL;
      r_s2  <= IDLE_LEVEL;
      r_any <= 1'b0;
    end else begin
      r_s1  <= in_raw;
      r_s2  <= r_s1;
      r_any <= |(w_stable ^ IDLE_LEVEL);
    end
  assign in_stable   = w_stable;
  assign any_pressed = r_any;
  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DB_W-1:0]  r_db_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable, r_press, r_release;
    logic             w_diff, w_accept, w_active;
    assign w_diff   = r_s2[g] ^ r_stable;
    assign w_accept = w_diff && r_db_cnt == DB_LAST;
    assign w_active = r_stable ^ IDLE_LEVEL[g];
    // The count only advances while s2 disagrees, so any glitch back to the stable level restarts it.
    always_ff @(posedge clk27 or negedge reset_n)
      if (!reset_n) begin
        r_db_cnt  <= '0;
        r_stable  <= IDLE_LEVEL[g];
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_db_cnt  <= (w_diff && !w_accept) ? r_db_cnt + DB_W'(1) : '0;
        r_stable  <= w_accept ? r_s2[g] : r_stable;
        r_press   <= w_accept && !w_active;
        r_release <= w_accept && w_active;
        // A press counted in the same cycle as a clear survives as 1.
        r_cnt     <= clear_cnt ? CNT_W'(r_press) : r_cnt + CNT_W'(r_press);
      end
    assign w_stable[g]                = r_stable;
    assign press_pulse[g]             = r_press;
    assign release_pulse[g]           = r_release;
    assign press_cnt[g*CNT_W +: CNT_W] = r_cnt;
`ifdef INPUT_COND_LONGPRESS_EN
    logic [HW-1:0] r_hold;
    logic          r_long;
    // Hold counter saturates one past the threshold so the pulse fires once per press.
    always_ff @(posedge clk27 or negedge reset_n)
      if (!reset_n) begin
        r_hold <= '0;
        r_long <= 1'b0;
      end else begin
        r_long <= w_active && r_hold == LP_LAST;
        r_hold <= (w_accept || !w_active) ? '0 : (r_hold == LP_FULL ? r_hold : r_hold + HW'(1));
      end
    assign long_press[g] = r_long;
`else
    assign long_press[g] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed checks of input_conditioner against a history-based model
module tb_input_conditioner;
  localparam int CH = 2;
  localparam int D  = 4;
  localparam int L  = 10;
  localparam int W  = 8;
  localparam logic [CH-1:0] IDLE = 2'b11;
`ifdef INPUT_COND_LONGPRESS_EN
  localparam int LP_ON = 1;
`else
  localparam int LP_ON = 0;
`endif
  logic              clk27 = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear_cnt = 1'b0;
  logic [CH-1:0]     in_raw = IDLE;
  logic [CH-1:0]     in_stable, press_pulse, release_pulse, long_press;
  logic [CH*W-1:0]   press_cnt;
  logic              any_pressed;
  int                checks = 0;
  int                errors = 0;
  logic [CH-1:0]     m_stable, m_press, m_release, m_long;
  logic [CH-1:0]     m_hist [D+1];
  logic              m_any;
  int                m_cnt [CH];
  int                m_run [CH];
  int                n_press [CH];
  int                n_rel [CH];
  int                n_long [CH];
  int                n_any;
  int                rem [CH];
  int                lat, lp_press, lp_long;
  logic [CH-1:0]     r;

  input_conditioner #(
    .CHANNELS(CH), .IDLE_LEVEL(IDLE), .DEBOUNCE_CYCLES(D), .LONGPRESS_CYCLES(L), .CNT_W(W)
  ) dut (
    .clk27(clk27), .reset_n(reset_n), .in_raw(in_raw), .clear_cnt(clear_cnt),
    .in_stable(in_stable), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .press_cnt(press_cnt), .long_press(long_press), .any_pressed(any_pressed)
  );

  always #5 clk27 = ~clk27;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stable = IDLE; m_press = '0; m_release = '0; m_long = '0; m_any = 1'b0;
    for (int k = 0; k <= D; k++) m_hist[k] = IDLE;
    for (int c = 0; c < CH; c++) begin m_cnt[c] = 0; m_run[c] = 0; end
  endtask

  // A level is accepted once the last D synchronized samples (raw seen 2..D+1 edges ago) all differ from it.
  task automatic model_edge(input logic [CH-1:0] raw, input logic clr);
    logic [CH-1:0] ns, np, nr, nl;
    ns = m_stable; np = '0; nr = '0; nl = '0;
    for (int c = 0; c < CH; c++) begin
      bit settled;
      settled = 1'b1;
      for (int k = 1; k <= D; k++) if (m_hist[k][c] == m_stable[c]) settled = 1'b0;
      if (settled) begin
        ns[c] = ~m_stable[c];
        np[c] = ns[c] != IDLE[c];
        nr[c] = ns[c] == IDLE[c];
      end
      nl[c] = LP_ON != 0 && m_run[c] == L;
      m_run[c] = (ns[c] != IDLE[c]) ? m_run[c] + 1 : 0;
      m_cnt[c] = clr ? int'(m_press[c]) : (m_cnt[c] + int'(m_press[c])) % (1 << W);
    end
    m_any = m_stable != IDLE;
    for (int k = D; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = raw;
    m_stable = ns; m_press = np; m_release = nr; m_long = nl;
  endtask

  task automatic compare_all();
    check("in_stable", 32'(in_stable), 32'(m_stable));
    check("press_pulse", 32'(press_pulse), 32'(m_press));
    check("release_pulse", 32'(release_pulse), 32'(m_release));
    check("long_press", 32'(long_press), 32'(m_long));
    check("any_pressed", 32'(any_pressed), 32'(m_any));
    for (int c = 0; c < CH; c++) check("press_cnt", 32'(press_cnt[c*W +: W]), 32'(m_cnt[c]));
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) begin n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; end
    n_any = 0;
  endtask

  task automatic tick(input logic [CH-1:0] raw, input logic clr);
    in_raw = raw; clear_cnt = clr;
    @(posedge clk27);
    if (reset_n) model_edge(raw, clr); else model_reset();
    #1;
    compare_all();
    for (int c = 0; c < CH; c++) begin
      n_press[c] += int'(press_pulse[c]);
      n_rel[c]   += int'(release_pulse[c]);
      n_long[c]  += int'(long_press[c]);
    end
    n_any += int'(any_pressed);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(IDLE, 1'b0);
    tick(IDLE, 1'b0);
    reset_n = 1'b1;
    clear_counts();
  endtask

  initial begin
    model_reset();
    clear_counts();
    repeat (3) tick(2'b00, 1'b0);
    check("rst_stable", 32'(in_stable), 32'(2'b11));
    check("rst_cnt", 32'(press_cnt), 32'd0);
    check("rst_pulses", 32'({press_pulse, release_pulse, long_press, any_pressed}), 32'd0);
    reset_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(2'b00, 1'b0);
      if (lat == 0 && press_pulse == 2'b11) lat = i;
    end
    check("rst_press_lat", 32'(lat), 32'd6);
    repeat (8) tick(IDLE, 1'b0);

    do_reset();
    for (int i = 0; i < 20; i++) tick({1'b1, ((i / 2) % 2) == 0}, 1'b0);
    repeat (10) tick(IDLE, 1'b0);
    check("bounce_press", 32'(n_press[0]), 32'd0);
    check("bounce_stable", 32'(in_stable[0]), 32'd1);
    check("bounce_cnt", 32'(press_cnt[W-1:0]), 32'd0);

    do_reset();
    repeat (10) tick(2'b01, 1'b0);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(IDLE, 1'b0);
      if (lat == 0 && release_pulse[1]) lat = i;
    end
    check("clean_press", 32'(n_press[1]), 32'd1);
    check("clean_release", 32'(n_rel[1]), 32'd1);
    check("clean_cnt", 32'(press_cnt[2*W-1:W]), 32'd1);
    check("clean_rel_lat", 32'(lat), 32'd6);
    check("clean_any_cycles", 32'(n_any), 32'd10);

    do_reset();
    for (int p = 0; p < 257; p++) begin
      int lo, hi;
      lo = $urandom_range(6, 9);
      hi = $urandom_range(6, 9);
      repeat (lo) tick(2'b10, p == 256 && m_press[0]);
      repeat (hi) tick(IDLE, p == 256 && m_press[0]);
      if (p == 255) check("wrap_cnt", 32'(press_cnt[W-1:0]), 32'd0);
    end
    check("clr_on_press_cnt", 32'(press_cnt[W-1:0]), 32'd1);
    check("wrap_presses", 32'(n_press[0]), 32'd257);

    do_reset();
    lp_press = -1; lp_long = -1;
    for (int i = 0; i < 30; i++) begin
      tick(2'b10, 1'b0);
      if (lp_press < 0 && press_pulse[0]) lp_press = i;
      if (lp_long < 0 && long_press[0]) lp_long = i;
    end
    repeat (10) tick(IDLE, 1'b0);
    check("long_30_count", 32'(n_long[0]), 32'(LP_ON));
`ifdef INPUT_COND_LONGPRESS_EN
    check("long_latency", 32'(lp_long - lp_press), 32'd10);
`endif
    clear_counts();
    repeat (8) tick(2'b10, 1'b0);
    repeat (10) tick(IDLE, 1'b0);
    check("long_8_count", 32'(n_long[0]), 32'd0);
    check("long_8_press", 32'(n_press[0]), 32'd1);

    do_reset();
    repeat (10) tick(2'b01, 1'b0);
    repeat (4) tick(2'b00, 1'b0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check("arst_stable", 32'(in_stable), 32'(IDLE));
    check("arst_cnt", 32'(press_cnt), 32'd0);
    check("arst_any", 32'(any_pressed), 32'd0);
    check("arst_pulses", 32'({press_pulse, release_pulse, long_press}), 32'd0);
    tick(IDLE, 1'b0);
    reset_n = 1'b1;
    clear_counts();
    repeat (12) tick(IDLE, 1'b0);
    check("arst_no_events", 32'(n_press[0] + n_press[1] + n_rel[0] + n_rel[1]), 32'd0);

    do_reset();
    r = IDLE;
    for (int c = 0; c < CH; c++) rem[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (rem[c] == 0) begin
          r[c] = ~r[c];
          rem[c] = $urandom_range(1, 14);
        end else rem[c]--;
      end
      tick(r, $urandom_range(0, 31) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised successor to the ad-hoc 2-FF button/IR-level synchronizers in the top level. Conditions N asynchronous active-low/high digital inputs (front-panel buttons, lat-tester sensors) in the clk27 domain with 2-FF sync, per-channel debounce, press/release event pulses, per-channel wrapping event counters and optional long-press detection. Sits between the board pins and the CPU PIO / lcdbl_timeout, replacing raw btn_L usage.

Parameters:
CHANNELS, 2, number of input channels (1..16)
IDLE_LEVEL, {CHANNELS{1'b1}}, per-channel released level (1 = active-low button)
DEBOUNCE_CYCLES, 270000, clk27 cycles an input must hold a new level before acceptance (10 ms); min 1
LONGPRESS_CYCLES, 27000000, clk27 cycles held pressed before long_press fires (1 s); must be > DEBOUNCE_CYCLES
CNT_W, 8, width of each per-channel press counter

Ports:
clk27  input  1  system clock, 27 MHz
reset_n  input  1  asynchronous active-low reset
in_raw  input  CHANNELS  asynchronous pin inputs
clear_cnt  input  1  synchronous clear of all press counters
in_stable  output  CHANNELS  debounced level, IDLE_LEVEL polarity preserved
press_pulse  output  CHANNELS  1-cycle pulse on accepted idle->active transition
release_pulse  output  CHANNELS  1-cycle pulse on accepted active->idle transition
press_cnt  output  CHANNELS*CNT_W  packed counters, channel i at [i*CNT_W +: CNT_W]
long_press  output  CHANNELS  1-cycle pulse per press held LONGPRESS_CYCLES (0 if feature out)
any_pressed  output  1  OR of all channels currently in active level (registered)

Behaviour:
- Clock clk27; reset asynchronous, active-low; all state cleared by reset_n low, no synchronous reset besides clear_cnt.
- Reset values: sync stages and in_stable = IDLE_LEVEL; press_pulse, release_pulse, long_press, any_pressed = 0; press_cnt = 0; all debounce/hold counters = 0.
- Sync: two flops per channel (s1, s2); s2 is the only value consumed downstream.
- Debounce per channel, counter db_cnt width $clog2(DEBOUNCE_CYCLES+1):
  - s2 == in_stable: db_cnt <= 0.
  - s2 != in_stable and db_cnt < DEBOUNCE_CYCLES-1: db_cnt++.
  - s2 != in_stable and db_cnt == DEBOUNCE_CYCLES-1: in_stable <= s2, db_cnt <= 0, event pulse same edge.
  - Any glitch returning s2 to in_stable restarts the count from 0.
- Latency: a raw level held constant changes in_stable exactly DEBOUNCE_CYCLES+2 clk27 edges after the first edge that samples it.
- press_pulse[i]/release_pulse[i] registered, asserted in the cycle in_stable[i] first shows the new level, for exactly 1 cycle.
- press_cnt[i] increments on press_pulse[i], wraps 2^CNT_W-1 -> 0. clear_cnt zeroes all counters; clear_cnt coinciding with press_pulse[i] yields press_cnt[i] = 1.
- any_pressed = OR over channels of (in_stable != IDLE_LEVEL), registered from in_stable (one cycle after in_stable).
- Channels fully independent; simultaneous events on several channels each handled in the same cycle.
- reset_n asserted mid-debounce or mid-hold discards progress; no events generated on reset release (in_stable already equals IDLE_LEVEL).

Optional Feature:
INPUT_COND_LONGPRESS_EN
- Defined: per-channel hold counter ($clog2(LONGPRESS_CYCLES+1) bits) cleared on press_pulse, counts while in_stable is active; at count == LONGPRESS_CYCLES-1 long_press[i] pulses once, counter saturates; no repeat until released and pressed again. Release before threshold: no pulse, counter cleared.
- Not defined: no hold counters synthesised, long_press tied 0.

Test Plan:
- Reset: CHANNELS=2, DEBOUNCE_CYCLES=4, hold reset_n low with in_raw=2'b00 -> in_stable=2'b11, press_cnt=0, no pulses; after release and in_raw=00 held, press_pulse=2'b11 exactly 6 edges later.
- Bounce: in_raw[0] toggles 1->0->1 every 2 cycles for 20 cycles then stays 1 -> no press_pulse, in_stable[0]=1, press_cnt[0]=0.
- Clean press/release: in_raw[1] 0 for 10 cycles then 1 -> one press_pulse[1], press_cnt[1]=1, one release_pulse[1] 6 cycles after raw rise, any_pressed high only in between (+1 cycle lag).
- Wrap/clear: CNT_W=8, 256 clean presses on ch0 -> press_cnt[0]=0; clear_cnt on cycle of 257th press_pulse -> press_cnt[0]=1.
- Long press (INPUT_COND_LONGPRESS_EN, LONGPRESS_CYCLES=10): hold 30 cycles -> exactly one long_press[0] pulse 10 cycles after press_pulse; hold 8 cycles -> none; macro undefined -> long_press stays 0.
- Async reset mid-debounce: assert reset_n at db_cnt=2 -> outputs return to reset values immediately, no pulse after deassertion.
